// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   DEPTH-entry instruction/PC queue sitting between fetch and decode.
//   The head instruction is split into RV32I fields. While the queue is
//   empty, or while a flush is in progress, the NOP encoding is shown instead.
//   A flush discards every buffered entry and also any push in the same cycle.
//   drop_count_out is a saturating count of the entries thrown away by flushes.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   flush_in              discard all entries (and any same-cycle push)
//   in_valid_in/in_ready_out, instr_in, pc_in      fetch side handshake
//   out_valid_out/out_ready_in                      decode side handshake
//   opcode_out .. instr_31_7_out                    fields of selected instr
//   pc_out                head PC, zero when not valid
//   count_out             occupancy
//   drop_count_out        saturating flushed-entry counter
module instr_decode_queue #(
    parameter int          DEPTH          = 2,
    parameter int          PC_WIDTH       = 32,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          DROP_CNT_WIDTH = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        flush_in,
    input  logic                        in_valid_in,
    output logic                        in_ready_out,
    input  logic [31:0]                 instr_in,
    input  logic [PC_WIDTH-1:0]         pc_in,
    output logic                        out_valid_out,
    input  logic                        out_ready_in,
    output logic [6:0]                  opcode_out,
    output logic [4:0]                  rd_addr_out,
    output logic [2:0]                  func3_out,
    output logic [4:0]                  rs1_addr_out,
    output logic [4:0]                  rs2_addr_out,
    output logic [6:0]                  func7_out,
    output logic [24:0]                 instr_31_7_out,
    output logic [PC_WIDTH-1:0]         pc_out,
    output logic [$clog2(DEPTH):0]      count_out,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = DROP_CNT_WIDTH + CNT_W;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    logic [31:0]               instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]       pc_mem    [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    logic        push, pop;
    logic [31:0] sel_instr;
    logic [SUM_W-1:0] drop_sum;
    logic [DROP_CNT_WIDTH-1:0] drop_next;

    // Ready depends only on occupancy. A pop in the same cycle does not
    // open a slot for a push, so no combinational path runs from decode
    // ready back to fetch.
    assign in_ready_out  = (count != CNT_W'(DEPTH));
    assign out_valid_out = (count != '0) && !flush_in;

    assign push = in_valid_in && in_ready_out && !flush_in;
    assign pop  = out_valid_out && out_ready_in;

    assign sel_instr = out_valid_out ? instr_mem[rd_ptr] : NOP_INSTR;

    assign opcode_out     = sel_instr[6:0];
    assign rd_addr_out    = sel_instr[11:7];
    assign func3_out      = sel_instr[14:12];
    assign rs1_addr_out   = sel_instr[19:15];
    assign rs2_addr_out   = sel_instr[24:20];
    assign func7_out      = sel_instr[31:25];
    assign instr_31_7_out = sel_instr[31:7];
    assign pc_out         = out_valid_out ? pc_mem[rd_ptr] : '0;

    assign count_out      = count;
    assign drop_count_out = drop_cnt;

    // The sum is widened so that the carry can be seen before saturating.
    assign drop_sum  = SUM_W'(drop_cnt) + SUM_W'(count);
    assign drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX
                                                     : drop_sum[DROP_CNT_WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= drop_next;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The storage is not reset. Stale contents are never visible, because
    // the outputs are gated by occupancy.
    always_ff @(posedge clk_in) begin
        if (push && !rst_in) begin
            instr_mem[wr_ptr] <= instr_in;
            pc_mem[wr_ptr]    <= pc_in;
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
module tb_instr_decode_queue;

    localparam int DEPTH = 2;
    localparam int DW    = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, pc_o;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [24:0] i31_7;
    logic [1:0]  cnt;
    logic [DW-1:0] drop;

    int errors = 0;
    int checks = 0;

    // behavioural reference: an ordered list of entries plus a drop total
    logic [31:0] q_i[$];
    logic [31:0] q_p[$];
    int          m_drop = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(
        .DEPTH(DEPTH), .PC_WIDTH(32), .NOP_INSTR(NOP), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(in_ready),
        .instr_in(instr), .pc_in(pc),
        .out_valid_out(out_valid), .out_ready_in(out_ready),
        .opcode_out(opcode), .rd_addr_out(rd), .func3_out(func3),
        .rs1_addr_out(rs1), .rs2_addr_out(rs2), .func7_out(func7),
        .instr_31_7_out(i31_7), .pc_out(pc_o),
        .count_out(cnt), .drop_count_out(drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, compare the DUT with the reference
    // model mid-cycle, then advance the model and the clock.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input bit chk);
        int          sz;
        logic        ev, er;
        logic [31:0] es, ep;
        rst = r; flush = f; in_valid = iv; instr = ins; pc = p; out_ready = ordy;
        #2;
        sz = q_i.size();
        ev = (sz != 0) && !f;
        er = (sz != DEPTH);
        es = ev ? q_i[0] : NOP;
        ep = ev ? q_p[0] : 32'h0;
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(ev));
            check("in_ready",  32'(in_ready),  32'(er));
            check("opcode",    32'(opcode),    32'(es & 32'h7f));
            check("rd",        32'(rd),        (es >> 7) & 32'h1f);
            check("func3",     32'(func3),     (es >> 12) & 32'h7);
            check("rs1",       32'(rs1),       (es >> 15) & 32'h1f);
            check("rs2",       32'(rs2),       (es >> 20) & 32'h1f);
            check("func7",     32'(func7),     es >> 25);
            check("instr_31_7", 32'(i31_7),    es >> 7);
            check("pc_out",    pc_o,           ep);
            check("count",     32'(cnt),       32'(sz));
            check("drop_count", 32'(drop),     32'(m_drop));
        end
        if (r) begin
            q_i.delete(); q_p.delete(); m_drop = 0;
        end else if (f) begin
            m_drop = (m_drop + sz > DROP_MAX) ? DROP_MAX : m_drop + sz;
            q_i.delete(); q_p.delete();
        end else begin
            if (ev && ordy) begin
                void'(q_i.pop_front()); void'(q_p.pop_front());
            end
            if (iv && er) begin
                q_i.push_back(ins); q_p.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then idle
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // single push of addi x1,x1,10, popped the cycle after
        cyc(0, 0, 1, 32'h00A0_8093, 32'h100, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // stall: fill to full, the third push is held by fetch
        cyc(0, 0, 1, 32'h0010_0113, 32'h0, 0, 1);
        cyc(0, 0, 1, 32'h0020_8193, 32'h4, 0, 1);
        cyc(0, 0, 1, 32'h4031_0233, 32'h8, 0, 1);
        cyc(0, 0, 1, 32'h4031_0233, 32'h8, 0, 1);
        // release the stall: pc 0x0 and 0x4 pop, then 0x8 is accepted
        cyc(0, 0, 1, 32'h4031_0233, 32'h8, 1, 1);
        cyc(0, 0, 1, 32'h4031_0233, 32'h8, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // a full queue flushed in the same cycle as a push
        cyc(0, 0, 1, 32'hFFFF_FFFF, 32'h20, 0, 1);
        cyc(0, 0, 1, 32'h8765_4321, 32'h24, 0, 1);
        cyc(0, 1, 1, 32'h1234_5678, 32'h28, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // simultaneous push and pop at count 1; pointers wrap
        cyc(0, 0, 1, 32'hABCD_E0B3, 32'h300, 1, 1);
        for (int k = 1; k <= 10; k++)
            cyc(0, 0, 1, $urandom, 32'h300 + 32'(4 * k), 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // drop counter saturation, starting from reset
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, $urandom, $urandom, 0, 1);
            cyc(0, 0, 1, $urandom, $urandom, 0, 1);
            cyc(0, 1, 1, $urandom, $urandom, 0, 1);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        // reset and flush together: reset wins
        cyc(0, 0, 1, $urandom, $urandom, 0, 1);
        cyc(1, 1, 1, $urandom, $urandom, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        // randomized traffic
        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                1'($urandom), $urandom, $urandom,
                ($urandom_range(3) != 0), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
